// File: rtl/imem_dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch and load/store.
// One transaction at a time; read data returns MEM_LAT cycles after the grant.
module imem_dmem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wmask,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  typedef enum logic {IDLE, RD_WAIT} state_t;
  typedef enum logic {SRC_INSTR, SRC_DATA} src_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t     state;
  src_t       owner;
  src_t       last_grant;
  logic [2:0] lat_cnt;

  logic rd_final;
  logic can_grant;
  logic pick_i;
  logic rd_grant;

  // The last RD_WAIT cycle doubles as a grant slot so MEM_LAT=1 reads stream one per cycle.
  assign rd_final  = (state == RD_WAIT) && (lat_cnt == 3'd1);
  assign can_grant = !reset && ((state == IDLE) || rd_final);
  assign pick_i    = i_req && (!d_req || (last_grant == SRC_DATA));

  assign i_gnt    = can_grant && pick_i;
  assign d_gnt    = can_grant && d_req && !pick_i;
  assign rd_grant = i_gnt || (d_gnt && !d_we);

  assign i_rvalid = !reset && rd_final && (owner == SRC_INSTR);
  assign d_rvalid = !reset && rd_final && (owner == SRC_DATA);
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;
  assign busy     = !reset && (state == RD_WAIT);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (i_gnt) begin
      mem_en   = 1'b1;
      mem_addr = i_addr;
    end else if (d_gnt) begin
      mem_en   = 1'b1;
      mem_addr = d_addr;
      if (d_we) begin
        mem_we    = 1'b1;
        mem_wdata = d_wdata;
        mem_wmask = d_wmask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= 3'd0;
      owner      <= SRC_INSTR;
      last_grant <= SRC_DATA;
    end else begin
      if (i_gnt) begin
        last_grant <= SRC_INSTR;
      end else if (d_gnt) begin
        last_grant <= SRC_DATA;
      end

      if (rd_grant) begin
        state   <= RD_WAIT;
        lat_cnt <= LAT;
        owner   <= i_gnt ? SRC_INSTR : SRC_DATA;
      end else if (state == RD_WAIT) begin
        if (lat_cnt == 3'd1) begin
          state   <= IDLE;
          lat_cnt <= 3'd0;
        end else begin
          lat_cnt <= lat_cnt - 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter; three instances cover MEM_LAT = 1, 3 and 4 on shared stimulus.
module tb_imem_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            i_req;
  logic [AW-1:0]   i_addr;
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_wmask;
  logic [DW-1:0]   mem_rdata;

  logic            i_gnt     [3];
  logic            i_rvalid  [3];
  logic [DW-1:0]   i_rdata   [3];
  logic            d_gnt     [3];
  logic            d_rvalid  [3];
  logic [DW-1:0]   d_rdata   [3];
  logic            mem_en    [3];
  logic            mem_we    [3];
  logic [AW-1:0]   mem_addr  [3];
  logic [DW-1:0]   mem_wdata [3];
  logic [DW/8-1:0] mem_wmask [3];
  logic            busy      [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt[0]), .i_rvalid(i_rvalid[0]), .i_rdata(i_rdata[0]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_wmask(mem_wmask[0]), .mem_rdata(mem_rdata), .busy(busy[0])
  );

  imem_dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt[1]), .i_rvalid(i_rvalid[1]), .i_rdata(i_rdata[1]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_wmask(mem_wmask[1]), .mem_rdata(mem_rdata), .busy(busy[1])
  );

  imem_dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(4)) u_lat4 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt[2]), .i_rvalid(i_rvalid[2]), .i_rdata(i_rdata[2]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_gnt(d_gnt[2]), .d_rvalid(d_rvalid[2]), .d_rdata(d_rdata[2]),
    .mem_en(mem_en[2]), .mem_we(mem_we[2]), .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]),
    .mem_wmask(mem_wmask[2]), .mem_rdata(mem_rdata), .busy(busy[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic clear_inputs();
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b1;
    clear_inputs();
    cyc();
    reset = 1'b0;
    settle();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    mem_rdata = 32'h0;

    // Reset forces grants off even with both requests asserted.
    cyc();
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1;
    settle();
    chk("rst_i_gnt", {31'b0, i_gnt[0]}, 32'd0);
    chk("rst_d_gnt", {31'b0, d_gnt[0]}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en[0]}, 32'd0);
    cyc();
    clear_inputs();
    settle();
    chk("rst_busy", {31'b0, busy[0]}, 32'd0);
    chk("rst_mem_addr", mem_addr[0], 32'd0);
    cyc();
    reset = 1'b0;
    settle();
    chk("post_rst_busy", {31'b0, busy[2]}, 32'd0);
    chk("post_rst_rvalid", {31'b0, d_rvalid[0]}, 32'd0);

    // Single fetch, MEM_LAT=1
    cyc();
    i_req = 1'b1; i_addr = 32'h0000_0010;
    settle();
    chk("fetch_i_gnt", {31'b0, i_gnt[0]}, 32'd1);
    chk("fetch_mem_addr", mem_addr[0], 32'h10);
    chk("fetch_mem_en", {31'b0, mem_en[0]}, 32'd1);
    chk("fetch_mem_we", {31'b0, mem_we[0]}, 32'd0);
    chk("fetch_busy0", {31'b0, busy[0]}, 32'd0);
    cyc();
    i_req = 1'b0; mem_rdata = 32'hA5A5_0001;
    settle();
    chk("fetch_i_rvalid", {31'b0, i_rvalid[0]}, 32'd1);
    chk("fetch_i_rdata", i_rdata[0], 32'hA5A5_0001);
    chk("fetch_busy1", {31'b0, busy[0]}, 32'd1);
    chk("fetch_no_gnt", {31'b0, i_gnt[0]}, 32'd0);
    cyc();
    settle();
    chk("fetch_busy2", {31'b0, busy[0]}, 32'd0);
    chk("fetch_rvalid2", {31'b0, i_rvalid[0]}, 32'd0);

    // Contention after reset: I, D, I, D
    do_reset();
    cyc();
    i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    settle();
    chk("cont0_i_gnt", {31'b0, i_gnt[0]}, 32'd1);
    chk("cont0_d_gnt", {31'b0, d_gnt[0]}, 32'd0);
    chk("cont0_addr", mem_addr[0], 32'h40);
    cyc();
    mem_rdata = 32'h1111_0000;
    settle();
    chk("cont1_d_gnt", {31'b0, d_gnt[0]}, 32'd1);
    chk("cont1_i_gnt", {31'b0, i_gnt[0]}, 32'd0);
    chk("cont1_addr", mem_addr[0], 32'h80);
    chk("cont1_i_rvalid", {31'b0, i_rvalid[0]}, 32'd1);
    chk("cont1_i_rdata", i_rdata[0], 32'h1111_0000);
    cyc();
    mem_rdata = 32'h2222_0000;
    settle();
    chk("cont2_i_gnt", {31'b0, i_gnt[0]}, 32'd1);
    chk("cont2_d_gnt", {31'b0, d_gnt[0]}, 32'd0);
    chk("cont2_d_rvalid", {31'b0, d_rvalid[0]}, 32'd1);
    chk("cont2_d_rdata", d_rdata[0], 32'h2222_0000);
    cyc();
    settle();
    chk("cont3_d_gnt", {31'b0, d_gnt[0]}, 32'd1);
    chk("cont3_i_gnt", {31'b0, i_gnt[0]}, 32'd0);
    chk("cont3_i_rvalid", {31'b0, i_rvalid[0]}, 32'd1);
    cyc();
    clear_inputs();
    settle();
    chk("cont4_d_rvalid", {31'b0, d_rvalid[0]}, 32'd1);
    chk("cont4_no_gnt", {30'b0, i_gnt[0], d_gnt[0]}, 32'd0);

    // Store passthrough followed by a next-cycle store
    do_reset();
    cyc();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'b0011;
    settle();
    chk("st_d_gnt", {31'b0, d_gnt[0]}, 32'd1);
    chk("st_mem_en", {31'b0, mem_en[0]}, 32'd1);
    chk("st_mem_we", {31'b0, mem_we[0]}, 32'd1);
    chk("st_mem_addr", mem_addr[0], 32'h100);
    chk("st_mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
    chk("st_mem_wmask", {28'b0, mem_wmask[0]}, 32'h3);
    cyc();
    d_addr = 32'h104; d_wdata = 32'h1234_5678; d_wmask = 4'b1111;
    settle();
    chk("st2_d_gnt", {31'b0, d_gnt[0]}, 32'd1);
    chk("st2_d_rvalid", {31'b0, d_rvalid[0]}, 32'd0);
    chk("st2_busy", {31'b0, busy[0]}, 32'd0);
    chk("st2_wdata", mem_wdata[0], 32'h1234_5678);
    cyc();
    clear_inputs();
    settle();
    chk("st3_d_rvalid", {31'b0, d_rvalid[0]}, 32'd0);
    chk("st3_wdata_idle", mem_wdata[0], 32'd0);

    // Latency: MEM_LAT=3 load; fetch raised meanwhile waits for the rvalid cycle
    do_reset();
    cyc();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    settle();
    chk("lat_d_gnt", {31'b0, d_gnt[1]}, 32'd1);
    chk("lat_addr", mem_addr[1], 32'h300);
    cyc();
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h44;
    settle();
    chk("lat1_i_gnt", {31'b0, i_gnt[1]}, 32'd0);
    chk("lat1_rvalid", {31'b0, d_rvalid[1]}, 32'd0);
    chk("lat1_busy", {31'b0, busy[1]}, 32'd1);
    cyc();
    settle();
    chk("lat2_i_gnt", {31'b0, i_gnt[1]}, 32'd0);
    chk("lat2_rvalid", {31'b0, d_rvalid[1]}, 32'd0);
    cyc();
    mem_rdata = 32'h3333_CAFE;
    settle();
    chk("lat3_d_rvalid", {31'b0, d_rvalid[1]}, 32'd1);
    chk("lat3_d_rdata", d_rdata[1], 32'h3333_CAFE);
    chk("lat3_i_gnt", {31'b0, i_gnt[1]}, 32'd1);
    chk("lat3_addr", mem_addr[1], 32'h44);
    cyc();
    i_req = 1'b0;
    settle();
    chk("lat4_d_rvalid", {31'b0, d_rvalid[1]}, 32'd0);
    chk("lat4_busy", {31'b0, busy[1]}, 32'd1);

    // Reset mid-read: MEM_LAT=4 load dropped, then tie goes to INSTR
    do_reset();
    cyc();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    settle();
    chk("mid_d_gnt", {31'b0, d_gnt[2]}, 32'd1);
    cyc();
    d_req = 1'b0;
    settle();
    chk("mid_busy", {31'b0, busy[2]}, 32'd1);
    cyc();
    reset = 1'b1;
    settle();
    chk("mid_rst_rvalid", {31'b0, d_rvalid[2]}, 32'd0);
    chk("mid_rst_mem_en", {31'b0, mem_en[2]}, 32'd0);
    cyc();
    reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h500; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    settle();
    chk("mid_tie_i_gnt", {31'b0, i_gnt[2]}, 32'd1);
    chk("mid_tie_d_gnt", {31'b0, d_gnt[2]}, 32'd0);
    chk("mid_tie_rvalid", {31'b0, d_rvalid[2]}, 32'd0);
    cyc();
    i_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("mid_wait_d_rvalid", {31'b0, d_rvalid[2]}, 32'd0);
      chk("mid_wait_d_gnt", {31'b0, d_gnt[2]}, 32'd0);
      chk("mid_wait_busy", {31'b0, busy[2]}, 32'd1);
      cyc();
    end
    mem_rdata = 32'h5555_AAAA;
    settle();
    chk("mid_i_rvalid", {31'b0, i_rvalid[2]}, 32'd1);
    chk("mid_i_rdata", i_rdata[2], 32'h5555_AAAA);
    chk("mid_d_rvalid_final", {31'b0, d_rvalid[2]}, 32'd0);
    chk("mid_d_gnt_final", {31'b0, d_gnt[2]}, 32'd1);

    // Three back-to-back stores then a load, MEM_LAT=1
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200 + 32'(4 * k);
      d_wdata = 32'hC0DE_0000 + 32'(k); d_wmask = 4'b1111;
      settle();
      chk("bb_st_d_gnt", {31'b0, d_gnt[0]}, 32'd1);
      chk("bb_st_mem_we", {31'b0, mem_we[0]}, 32'd1);
      chk("bb_st_addr", mem_addr[0], 32'h200 + 32'(4 * k));
      chk("bb_st_wdata", mem_wdata[0], 32'hC0DE_0000 + 32'(k));
    end
    cyc();
    d_we = 1'b0; d_addr = 32'h20C; d_wdata = 32'hFFFF_FFFF; d_wmask = 4'b1111;
    settle();
    chk("bb_ld_d_gnt", {31'b0, d_gnt[0]}, 32'd1);
    chk("bb_ld_mem_we", {31'b0, mem_we[0]}, 32'd0);
    chk("bb_ld_wdata", mem_wdata[0], 32'd0);
    chk("bb_ld_wmask", {28'b0, mem_wmask[0]}, 32'd0);
    cyc();
    d_req = 1'b0;
    mem_rdata = 32'h7777_0BAD;
    settle();
    chk("bb_ld_d_rvalid", {31'b0, d_rvalid[0]}, 32'd1);
    chk("bb_ld_d_rdata", d_rdata[0], 32'h7777_0BAD);
    cyc();
    settle();
    chk("bb_ld_done", {31'b0, d_rvalid[0]}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-ported unified memory between the core's instruction-fetch port (PC side) and its load/store port (ALU address / write-data side).
- Handles one memory transaction at a time.
- Grants between the two requesters round-robin, and returns read data after a fixed memory latency.
- Sits between the core's fetch/LSU request logic and the memory macro; the stall logic uses busy and the grant signals.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, cycles from mem_en (read) to mem_rdata valid; legal range 1..4

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_req  in  1  instruction fetch request (read-only)
- i_addr  in  AW  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  DW  fetch data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_wmask  in  DW/8  byte-lane write mask
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DW  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_wmask  out  DW/8  memory byte mask
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after a read strobe
- busy  out  1  a read is outstanding

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset effects: state = IDLE, lat_cnt = 0, owner cleared, last_grant = DATA.
  - All outputs are 0 on the cycle after reset is sampled.
  - While reset is high, gnt, rvalid and mem_en are forced to 0.
- FSM states: IDLE, RD_WAIT.
- Grant (combinational, in IDLE, or in RD_WAIT on its final cycle):
  - One requester only: that requester is granted.
  - Both requesting: the one not equal to last_grant wins.
  - last_grant updates on every grant.
  - At most one gnt per cycle. The winner's fields drive mem_* in the same cycle, with mem_en = 1.
  - The loser sees gnt = 0 and must hold req and its fields stable until granted.
- Instruction grant:
  - mem_we = 0, mem_wmask = 0.
  - Always a read: owner = INSTR, go to RD_WAIT, lat_cnt = MEM_LAT.
- Data store (d_we = 1):
  - mem_we = 1, mem_wmask = d_wmask.
  - Completes in the grant cycle, with no rvalid; state stays IDLE.
  - Back-to-back stores on consecutive cycles are legal.
- Data load: owner = DATA, go to RD_WAIT, lat_cnt = MEM_LAT.
- RD_WAIT:
  - lat_cnt decrements each cycle.
  - In the cycle lat_cnt == 1 (counting starts the cycle after the grant):
    - The owner's rvalid = 1 and its rdata = mem_rdata, passed through combinationally.
  - The final RD_WAIT cycle may issue a new grant:
    - New grant is a read: reload lat_cnt, stay in RD_WAIT.
    - New grant is a store: return to IDLE.
    - No grant: return to IDLE.
  - No other grants are given during RD_WAIT.
  - busy = 1 throughout RD_WAIT.
- Throughput: with MEM_LAT = 1, back-to-back reads give one grant per cycle, with rvalid one cycle after each gnt.
- rdata outside an rvalid cycle is don't-care; the bench must not check it.
- A request that drops before its grant is legal and is simply not served.
- Reset mid-operation: an outstanding read is dropped. No rvalid is ever produced for it, including after reset is released.
- Width rules:
  - No address translation; addresses pass through unchanged.
  - mem_wdata = d_wdata only on store grants, otherwise 0.

Test Plan:
- Single fetch: MEM_LAT = 1, i_req = 1 with i_addr = 0x0000_0010 for one cycle.
  - Required: i_gnt = 1 and mem_addr = 0x10 in cycle 0; i_rvalid = 1 with i_rdata = mem_rdata in cycle 1; busy = 1 in cycle 1 only.
- Contention after reset: i_req and d_req both held from cycle 0, d_we = 0.
  - Required: grants in order I, D, I, D on consecutive RD_WAIT-final cycles; no cycle with both gnts high.
- Store passthrough: d_req = 1, d_we = 1, d_addr = 0x100, d_wdata = 0xDEADBEEF, d_wmask = 4'b0011.
  - Required: in the grant cycle, mem_we = 1 with exactly those values; no d_rvalid ever; next-cycle grant possible.
- Latency: MEM_LAT = 3, single load.
  - Required: d_rvalid exactly 3 cycles after d_gnt; i_req raised meanwhile is granted only in the d_rvalid cycle.
- Reset mid-read: MEM_LAT = 4, load granted, reset pulsed 2 cycles later.
  - Required: no d_rvalid afterwards; busy = 0; the first grant after reset goes to INSTR on a tie.
- Back-to-back stores then load: three stores on consecutive cycles, then one load.
  - Required: three consecutive d_gnt with mem_we = 1, then a load gnt with mem_we = 0 and d_rvalid MEM_LAT cycles later.
